// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD stream controller slice.
package gcd_pkg;
  localparam int unsigned BYTES_DEF = 2;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/gcd_fifo.sv
// Operand-pair FIFO with a registered head word; an entry is visible the cycle after its push.
module gcd_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned W2    = 32,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W2-1:0] wdata,
  output logic [W2-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W2-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W2-1:0] rdata_q, rdata_d;
  logic          push_en, pop_en;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = rdata_q;

  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + 1'b1;
    end else if (pop_en && !push_en) begin
      count_d = count_q - 1'b1;
    end
    // Look ahead to the next head; a write landing on that slot bypasses the array.
    rdata_d = (push_en && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: rtl/gcd_stream_ctrl.sv
// Streams operand pairs through an iterative GCD core, bypassing zero operands
// and reporting the number of core RUN cycles with each result.
module gcd_stream_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned BYTES = BYTES_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = 8*BYTES+2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   in_a,
  input  logic [8*BYTES-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   out_gcd,
  output logic [CW-1:0]        out_cycles,
  output logic                 gcd_load,
  output logic [8*BYTES-1:0]   gcd_a,
  output logic [8*BYTES-1:0]   gcd_b,
  input  logic [8*BYTES-1:0]   gcd_o,
  input  logic                 gcd_fin
);
  localparam int unsigned W = 8*BYTES;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    gcd_q, gcd_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            load_q, load_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*W-1:0]  fifo_rdata;
  logic [W-1:0]    head_a, head_b;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign head_a     = fifo_rdata[2*W-1:W];
  assign head_b     = fifo_rdata[W-1:0];

  gcd_fifo #(
    .W2    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({in_a, in_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          a_d = head_a;
          b_d = head_b;
          // The core never converges with a zero operand, so answer it here.
          if ((head_a == '0) || (head_b == '0)) begin
            gcd_d   = head_a | head_b;
            cyc_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        cnt_d = cnt_inc;
        if (gcd_fin) begin
          gcd_d   = gcd_o;
          cyc_d   = cnt_inc;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      cyc_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      cyc_q   <= cyc_d;
      load_q  <= load_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_gcd    = gcd_q;
  assign out_cycles = cyc_q;
  assign gcd_load   = load_q;
  assign gcd_a      = a_q;
  assign gcd_b      = b_q;
endmodule

// File: tb/tb_gcd_stream_ctrl.sv
// Scoreboard bench for gcd_stream_ctrl with a behavioural subtract/swap core attached.
module tb_gcd_stream_ctrl;
  localparam int unsigned BYTES = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 8*BYTES;
  localparam int unsigned CW    = 8*BYTES+2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_gcd;
  logic [CW-1:0] out_cycles;
  logic          gcd_load;
  logic [W-1:0]  gcd_a, gcd_b, gcd_o;
  logic          gcd_fin;

  logic [W-1:0]  ca, cb;
  logic          core_fin;
  logic          force_fin = 1'b0;

  int            checks = 0;
  int            failures = 0;
  int            load_cnt = 0;
  int            rdy_mode = 0;

  typedef struct packed {
    logic [W-1:0]  g;
    logic [CW-1:0] c;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gcd_stream_ctrl #(
    .BYTES (BYTES),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_cycles (out_cycles),
    .gcd_load   (gcd_load),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_o      (gcd_o),
    .gcd_fin    (gcd_fin)
  );

  // Behavioural core: one swap or subtract per cycle, fin when the operands match.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ca <= '0;
      cb <= '0;
    end else if (gcd_load) begin
      ca <= gcd_a;
      cb <= gcd_b;
    end else if (ca != cb) begin
      if (ca < cb) begin
        ca <= cb;
        cb <= ca;
      end else begin
        ca <= ca - cb;
      end
    end
  end
  assign core_fin = (ca == cb);
  assign gcd_fin  = core_fin | (force_fin & gcd_load);
  assign gcd_o    = ca;

  function automatic logic [W-1:0] ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [CW-1:0] ref_cycles(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    longint unsigned n;
    longint unsigned maxc = (64'd1 << CW) - 1;
    if (a == 0 || b == 0) return '0;
    n = 1;
    while (x != y) begin
      if (x < y) begin
        t = x; x = y; y = t;
      end else begin
        x = x - y;
      end
      n++;
    end
    if (n > maxc) n = maxc;
    return n[CW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && gcd_load) load_cnt++;
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got gcd=%0d cycles=%0d required=none", out_gcd, out_cycles);
        end else begin
          e = exp_q.pop_front();
          if (out_gcd !== e.g || out_cycles !== e.c) begin
            failures++;
            $display("FAIL result got gcd=%0d cycles=%0d required gcd=%0d cycles=%0d",
                     out_gcd, out_cycles, e.g, e.c);
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the pair is taken.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
    bit ok = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    waits = 0;
    while (!ok && waits < 3000) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else waits++;
    end
    if (ok) begin
      exp_q.push_back('{g: ref_gcd(a, b), c: ref_cycles(a, b)});
    end else begin
      chk("send_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int l0;
    int stalls;
    logic [W-1:0] ra, rb;

    fork
      monitor();
      ready_drv();
      begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_gcd_load",   64'(gcd_load),   64'd0);
    chk("rst_gcd_a",      64'(gcd_a),      64'd0);
    chk("rst_gcd_b",      64'(gcd_b),      64'd0);
    chk("rst_out_gcd",    64'(out_gcd),    64'd0);
    chk("rst_out_cycles", 64'(out_cycles), 64'd0);
    @(posedge clk);
    #1;

    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    l0 = load_cnt;
    send(16'd12, 16'd18, w);
    drain();
    chk("load_pulses_12_18", 64'(load_cnt - l0), 64'd1);

    send(16'd7, 16'd7, w);
    drain();

    l0 = load_cnt;
    send(16'd0, 16'd5, w);
    send(16'd9, 16'd0, w);
    send(16'd0, 16'd0, w);
    drain();
    chk("bypass_load_pulses", 64'(load_cnt - l0), 64'd0);

    // Backpressure: one pair parks in DONE, four fill the FIFO.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    stalls = 0;
    send(16'd3, 16'd6, w);  stalls += w;
    send(16'd10, 16'd4, w); stalls += w;
    send(16'd5, 16'd5, w);  stalls += w;
    send(16'd0, 16'd7, w);  stalls += w;
    send(16'd21, 16'd14, w); stalls += w;
    chk("five_accepts_no_stall", 64'(stalls), 64'd0);
    @(negedge clk);
    chk("in_ready_full", 64'(in_ready), 64'd0);
    repeat (20) @(negedge clk);
    chk("in_ready_still_full", 64'(in_ready), 64'd0);
    chk("out_valid_held", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    send(16'd8, 16'd20, w);
    drain();

    // Reset mid-RUN aborts the pair and drops everything buffered.
    send(16'd65535, 16'd1, w);
    w = 0;
    while (!gcd_load && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("long_pair_loaded", 64'(gcd_load), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready",  64'(in_ready),  64'd1);
    chk("post_rst_gcd_load",  64'(gcd_load),  64'd0);
    @(posedge clk);
    #1;
    send(16'd4, 16'd6, w);
    drain();

    // Stale fin during the LOAD cycle must not end the new pair early.
    force_fin = 1'b1;
    send(16'd9, 16'd9, w);
    drain();
    send(16'd8, 16'd12, w);
    drain();
    force_fin = 1'b0;

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
      send(ra, rb, w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gcd_stream_ctrl.md
Name: gcd_stream_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the iterative subtract/swap GCD core (load, fin, o).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Loads each pair into the core, waits for fin, then returns the result plus an iteration count on a valid/ready output stream.
- Resolves zero operands itself, because the core never terminates when one operand is 0.

Parameters:
- BYTES, 2, operand/result width in bytes; W = 8*BYTES.
- DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2.
- CW, 8*BYTES+2, width of the saturating iteration counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  W  operand a.
- in_b  input  W  operand b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_gcd  output  W  gcd(a,b).
- out_cycles  output  CW  core RUN cycles used; 0 for bypassed pairs.
- gcd_load  output  1  load pulse to the core; registered, glitch-free.
- gcd_a  output  W  operand a to the core.
- gcd_b  output  W  operand b to the core.
- gcd_o  input  W  core result.
- gcd_fin  input  1  core done flag (A==B, combinational in the core).

Behaviour:
- Reset (asynchronous): state=IDLE, FIFO empty.
  - in_ready=1, out_valid=0, gcd_load=0.
  - gcd_a=0, gcd_b=0, out_gcd=0, out_cycles=0.
- FIFO:
  - Push on in_valid&&in_ready; in_ready = !full.
  - A pair is poppable in the cycle after its push; there is no fall-through.
  - Simultaneous push and pop when full is not allowed, since in_ready is already 0.
  - Simultaneous push and pop at any other fill level is legal and leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, FIFO non-empty: pop the pair into gcd_a/gcd_b registers.
  - If a==0 or b==0: out_gcd <= a|b (this gives gcd(0,0)=0), out_cycles <= 0, next state DONE. gcd_load stays 0.
  - Otherwise: next state LOAD, with the counter cleared.
- LOAD (exactly 1 cycle):
  - gcd_load=1.
  - gcd_fin is ignored in this cycle because it may reflect the previous pair.
  - Next state RUN.
- RUN: each cycle the counter increments, saturating at all-ones.
  - When gcd_fin=1: out_gcd <= gcd_o, out_cycles <= counter+1 (saturating), next state DONE.
  - For a==b, fin is seen in the first RUN cycle, so out_cycles=1.
- DONE:
  - out_valid=1; out_gcd and out_cycles are held stable.
  - On out_ready: next state IDLE, and out_valid drops the next cycle.
  - Throughput is at most one result every 2 cycles; IDLE is always visited between results.
- gcd_a/gcd_b stay stable from the pop until the next pop.
- Reset in any state aborts the current pair, drops all buffered pairs and forces the reset values. The core must share the same reset routing as gcd_load, so the core is not left mid-run with a stale fin.
- out_valid is never asserted for an aborted pair.
- The block performs no arithmetic beyond the a|b bypass and the counter; result correctness is owned by the core.

Decomposition:
- Package gcd_pkg:
  - state enum typedef {IDLE, LOAD, RUN, DONE}.
  - Default localparams for BYTES and DEPTH.
- One sub-module: gcd_fifo (parameters W2=2*W, DEPTH).
  - Ports: clk, rst, push, pop, wdata, rdata, full, empty.
  - Registered read data.
  - Reset asynchronous, active-high.

Test Plan:
- Pair (12,18) with a real gcd core attached and out_ready=1 -> exactly one gcd_load pulse; out_gcd=6, out_cycles=5.
- Pair (7,7) -> out_gcd=7, out_cycles=1.
- Pairs (0,5), then (9,0), then (0,0) -> results 5, 9, 0, each with out_cycles=0; gcd_load never asserts.
- out_ready=0, push 6 pairs back-to-back:
  - in_ready falls after the 5th accept (1 in DONE plus 4 in FIFO).
  - Releasing out_ready drains all results in order; the 6th pair is accepted once space opens.
- Reset mid-RUN on pair (65535,1) -> out_valid=0 and in_ready=1 on the cycle after reset; subsequent pair (4,6) returns 2.
- gcd_fin forced high during the LOAD cycle (stale from the previous pair (9,9)) -> ignored; the new pair (8,12) returns 4.
